// File: rtl/gpia_pkg.sv
// Shared definitions for the general-purpose I/O port: q update mode encodings
// and the per-lane update function.
package gpia_pkg;

  typedef enum logic [1:0] {
    GPIA_MODE_LOAD = 2'b00,
    GPIA_MODE_SET  = 2'b01,
    GPIA_MODE_CLR  = 2'b10,
    GPIA_MODE_TOG  = 2'b11
  } gpia_mode_e;

  localparam int GPIA_LANE_BITS = 8;

  function automatic logic [GPIA_LANE_BITS-1:0] gpia_apply(
    input gpia_mode_e                mode,
    input logic [GPIA_LANE_BITS-1:0] q,
    input logic [GPIA_LANE_BITS-1:0] d
  );
    logic [GPIA_LANE_BITS-1:0] r;
    r = q;
    case (mode)
      GPIA_MODE_LOAD: r = d;
      GPIA_MODE_SET:  r = q | d;
      GPIA_MODE_CLR:  r = q & ~d;
      GPIA_MODE_TOG:  r = q ^ d;
      default:        r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpia_lane.sv
// One byte lane of the I/O port: output register, input synchroniser and
// sticky rising-edge event flags (event logic only with GPIA_PORT_IRQ_EN).
module gpia_lane
  import gpia_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic [1:0] mode_i,
  input  logic       stb_i,
  input  logic [7:0] d_i,
  input  logic       clr_i,
  input  logic [7:0] pin_i,
  output logic [7:0] q_o,
  output logic [7:0] pin_o,
  output logic [7:0] ev_o
);

  logic [7:0] q_reg;
  logic [7:0] sync_reg [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      q_reg <= '0;
    end else if (stb_i) begin
      q_reg <= gpia_apply(gpia_mode_e'(mode_i), q_reg, d_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= pin_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign q_o   = q_reg;
  assign pin_o = sync_reg[SYNC_STAGES-1];

`ifdef GPIA_PORT_IRQ_EN
  logic [7:0] dly_reg;
  logic [7:0] ev_reg;
  logic [7:0] ev_next;

  // A fresh edge wins over a coincident write-1-to-clear of the same bit.
  assign ev_next = (ev_reg & ~({8{clr_i}} & d_i)) | (pin_o & ~dly_reg);

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      dly_reg <= '0;
      ev_reg  <= '0;
    end else begin
      dly_reg <= pin_o;
      ev_reg  <= ev_next;
    end
  end

  assign ev_o = ev_reg;
`else
  logic unused_clr;
  assign unused_clr = clr_i;
  assign ev_o       = '0;
`endif

endmodule

// File: rtl/gpia_port.sv
// General-purpose I/O port: LANES byte lanes plus a registered interrupt.
// Event flags and irq_o are present only when GPIA_PORT_IRQ_EN is defined.
module gpia_port
  import gpia_pkg::*;
#(
  parameter  int WIDTH       = 64,
  parameter  int SYNC_STAGES = 2,
  localparam int LANES       = WIDTH / 8
) (
  input  logic             clk_i,
  input  logic             res_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [LANES-1:0] stb_i,
  output logic [WIDTH-1:0] q_o,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] pin_o,
  input  logic [LANES-1:0] evclr_i,
  output logic [WIDTH-1:0] ev_o,
  output logic             irq_o
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    gpia_lane #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_lane (
      .clk_i (clk_i),
      .res_i (res_i),
      .mode_i(mode_i),
      .stb_i (stb_i[gi]),
      .d_i   (d_i[gi*8 +: 8]),
      .clr_i (evclr_i[gi]),
      .pin_i (pin_i[gi*8 +: 8]),
      .q_o   (q_o[gi*8 +: 8]),
      .pin_o (pin_o[gi*8 +: 8]),
      .ev_o  (ev_o[gi*8 +: 8])
    );
  end

`ifdef GPIA_PORT_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk_i) begin
    if (res_i) irq_reg <= 1'b0;
    else       irq_reg <= |ev_o;
  end

  assign irq_o = irq_reg;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpia_port.sv
// Directed testbench for gpia_port (WIDTH=64, SYNC_STAGES=2); expectations
// follow GPIA_PORT_IRQ_EN so the same bench covers both builds.
module tb_gpia_port;

`ifdef GPIA_PORT_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res_i = 1'b1;
  logic [1:0]  mode_i = '0;
  logic [63:0] d_i = '0;
  logic [7:0]  stb_i = '0;
  logic [63:0] q_o;
  logic [63:0] pin_i = '0;
  logic [63:0] pin_o;
  logic [7:0]  evclr_i = '0;
  logic [63:0] ev_o;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  gpia_port #(.WIDTH(64), .SYNC_STAGES(2)) dut (
    .clk_i  (clk),
    .res_i  (res_i),
    .mode_i (mode_i),
    .d_i    (d_i),
    .stb_i  (stb_i),
    .q_o    (q_o),
    .pin_i  (pin_i),
    .pin_o  (pin_o),
    .evclr_i(evclr_i),
    .ev_o   (ev_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    res_i = 1'b1;
    cycle(2);
    total++; if (q_o !== 64'h0) begin bad++; $display("FAIL reset_q got=%h want=%h", q_o, 64'h0); end
    total++; if (pin_o !== 64'h0) begin bad++; $display("FAIL reset_pin got=%h want=%h", pin_o, 64'h0); end
    total++; if (ev_o !== 64'h0) begin bad++; $display("FAIL reset_ev got=%h want=%h", ev_o, 64'h0); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq_o); end
    res_i = 1'b0;
    cycle(1);
    $display("reset: q=%h ev=%h irq=%b", q_o, ev_o, irq_o);
  endtask

  task automatic test_load;
    mode_i = 2'b00; d_i = 64'h1122334455667788; stb_i = 8'h0F;
    cycle(1);
    stb_i = 8'h00;
    total++; if (q_o !== 64'h0000000055667788) begin bad++; $display("FAIL load got=%h want=%h", q_o, 64'h0000000055667788); end
    d_i = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(1);
    total++; if (q_o !== 64'h0000000055667788) begin bad++; $display("FAIL load_hold got=%h want=%h", q_o, 64'h0000000055667788); end
    $display("load: q=%h", q_o);
  endtask

  task automatic test_modes;
    mode_i = 2'b00; d_i = 64'h00000000000000FF; stb_i = 8'hFF;
    cycle(1);
    total++; if (q_o !== 64'h00000000000000FF) begin bad++; $display("FAIL mode_load got=%h want=%h", q_o, 64'hFF); end
    mode_i = 2'b11; d_i = 64'h0F0F; stb_i = 8'h03;
    cycle(1);
    total++; if (q_o !== 64'h0000000000000FF0) begin bad++; $display("FAIL mode_tog got=%h want=%h", q_o, 64'h0FF0); end
    mode_i = 2'b10; d_i = 64'hFFFF; stb_i = 8'h01;
    cycle(1);
    total++; if (q_o !== 64'h0000000000000F00) begin bad++; $display("FAIL mode_clr got=%h want=%h", q_o, 64'h0F00); end
    mode_i = 2'b01; d_i = 64'hA500_0000_0000_0003; stb_i = 8'h80;
    cycle(1);
    stb_i = 8'h00;
    total++; if (q_o !== 64'hA500000000000F00) begin bad++; $display("FAIL mode_set got=%h want=%h", q_o, 64'hA500000000000F00); end
    $display("modes: q=%h", q_o);
  endtask

  task automatic test_edge;
    pin_i = 64'h20;
    cycle(1);
    total++; if (pin_o !== 64'h0) begin bad++; $display("FAIL edge_pin1 got=%h want=%h", pin_o, 64'h0); end
    cycle(1);
    total++; if (pin_o !== 64'h20) begin bad++; $display("FAIL edge_pin2 got=%h want=%h", pin_o, 64'h20); end
    total++; if (ev_o !== 64'h0) begin bad++; $display("FAIL edge_ev2 got=%h want=%h", ev_o, 64'h0); end
    cycle(1);
    total++; if (ev_o !== (IRQ ? 64'h20 : 64'h0)) begin bad++; $display("FAIL edge_ev3 got=%h want=%h", ev_o, IRQ ? 64'h20 : 64'h0); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL edge_irq3 got=%b want=0", irq_o); end
    cycle(1);
    total++; if (irq_o !== IRQ) begin bad++; $display("FAIL edge_irq4 got=%b want=%b", irq_o, IRQ); end
    total++; if (ev_o !== (IRQ ? 64'h20 : 64'h0)) begin bad++; $display("FAIL edge_sticky got=%h want=%h", ev_o, IRQ ? 64'h20 : 64'h0); end
    $display("edge: pin=%h ev=%h irq=%b", pin_o, ev_o, irq_o);
  endtask

  task automatic test_clear;
    // Clear plus a concurrent lane-0 load: the two must not interact.
    evclr_i = 8'h01; d_i = 64'h20; mode_i = 2'b00; stb_i = 8'h01;
    cycle(1);
    evclr_i = 8'h00; stb_i = 8'h00;
    total++; if (ev_o !== 64'h0) begin bad++; $display("FAIL clr_ev got=%h want=%h", ev_o, 64'h0); end
    total++; if (irq_o !== IRQ) begin bad++; $display("FAIL clr_irq_hold got=%b want=%b", irq_o, IRQ); end
    total++; if (q_o !== 64'hA500000000000F20) begin bad++; $display("FAIL clr_q got=%h want=%h", q_o, 64'hA500000000000F20); end
    cycle(1);
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL clr_irq got=%b want=0", irq_o); end
    // New edge on bit 5 arriving in the same cycle as a clear of bit 5.
    pin_i = 64'h0;
    cycle(4);
    pin_i = 64'h20;
    cycle(2);
    evclr_i = 8'h01; d_i = 64'h20;
    cycle(1);
    evclr_i = 8'h00;
    total++; if (ev_o !== (IRQ ? 64'h20 : 64'h0)) begin bad++; $display("FAIL clr_priority got=%h want=%h", ev_o, IRQ ? 64'h20 : 64'h0); end
    $display("clear: ev=%h irq=%b q=%h", ev_o, irq_o, q_o);
  endtask

  task automatic test_reset_held;
    pin_i = 64'hFFFF_FFFF_FFFF_FFFF;
    mode_i = 2'b00; d_i = 64'hFFFF_FFFF_FFFF_FFFF; stb_i = 8'hFF; res_i = 1'b1;
    cycle(1);
    total++; if (q_o !== 64'h0) begin bad++; $display("FAIL rst_write_q got=%h want=%h", q_o, 64'h0); end
    total++; if (ev_o !== 64'h0) begin bad++; $display("FAIL rst_write_ev got=%h want=%h", ev_o, 64'h0); end
    stb_i = 8'h00;
    cycle(1);
    res_i = 1'b0;
    cycle(2);
    total++; if (ev_o !== 64'h0) begin bad++; $display("FAIL rst_early_ev got=%h want=%h", ev_o, 64'h0); end
    total++; if (pin_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rst_pin got=%h want=all-ones", pin_o); end
    cycle(1);
    total++; if (ev_o !== (IRQ ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0)) begin bad++; $display("FAIL rst_ev3 got=%h want=%h", ev_o, IRQ ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0); end
    evclr_i = 8'hFF;
    cycle(1);
    evclr_i = 8'h00;
    total++; if (ev_o !== 64'h0) begin bad++; $display("FAIL rst_ev_clr got=%h want=%h", ev_o, 64'h0); end
    cycle(3);
    total++; if (ev_o !== 64'h0) begin bad++; $display("FAIL rst_no_more got=%h want=%h", ev_o, 64'h0); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL rst_irq_end got=%b want=0", irq_o); end
    $display("reset_held: ev=%h irq=%b q=%h", ev_o, irq_o, q_o);
  endtask

  initial begin
    cycle(1);
    test_reset;
    test_load;
    test_modes;
    test_edge;
    test_clear;
    test_reset_held;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
